// File: rtl/match_judge.sv
// -----------------------------------------------------------------------------
// match_judge
//
// Match arbiter placed directly downstream of the card array. It watches the
// per-card selection vector and, once two cards are selected, compares their
// type IDs. The result goes back to every card as a one-cycle pulse: ms when
// the types match, mf when they differ. The block also counts matched pairs
// and raises a sticky done flag once every pair has been found.
//
// Optional feature macro:
//   JUDGE_DELAY_EN  when defined, a HOLD phase of DELAY_CYC cycles is placed
//                   between evaluation and the pulse. This keeps both cards
//                   visible to the player before the verdict is shown.
//
// Parameters:
//   N_CARDS    number of cards (even, 2..64)
//   TYPE_W     width of one card type ID
//   DELAY_CYC  HOLD length in clk cycles (used only with JUDGE_DELAY_EN)
//   CNT_W      derived width of match_cnt
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   sel        per-card selected flag
//   hidden     per-card matched/hidden flag (hidden cards are ignored)
//   types      card i type at [i*TYPE_W +: TYPE_W]
//   ms         match-success pulse, broadcast to all cards
//   mf         match-failure pulse, broadcast to all cards
//   busy       high whenever the judge is not idle
//   match_cnt  pairs matched since reset (saturates at N_CARDS/2)
//   done       sticky flag, set once match_cnt reaches N_CARDS/2
// -----------------------------------------------------------------------------
module match_judge #(
   parameter  int unsigned N_CARDS   = 16,
   parameter  int unsigned TYPE_W    = 3,
   parameter  int unsigned DELAY_CYC = 8,
   localparam int unsigned CNT_W     = $clog2(N_CARDS / 2 + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_CARDS-1:0]          sel,
   input  logic [N_CARDS-1:0]          hidden,
   input  logic [N_CARDS*TYPE_W-1:0]   types,
   output logic                        ms,
   output logic                        mf,
   output logic                        busy,
   output logic [CNT_W-1:0]            match_cnt,
   output logic                        done
);

   localparam int unsigned       PC_W = $clog2(N_CARDS + 1);
   localparam logic [CNT_W-1:0]  HALF = CNT_W'(N_CARDS / 2);

`ifdef JUDGE_DELAY_EN
   localparam int unsigned       DLY_W = $clog2(DELAY_CYC + 1);
   localparam logic [DLY_W-1:0]  DLY_LAST = DLY_W'(DELAY_CYC - 1);

   typedef enum logic [2:0] {
      IDLE,
      EVAL,
      HOLD,
      PULSE,
      WAIT
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      EVAL,
      PULSE,
      WAIT
   } state_t;
`endif

   // ---------------------------------------------------------------------------
   // Selection analysis: effective selection, its popcount, and the types of
   // the two lowest-indexed selected cards.
   // ---------------------------------------------------------------------------
   logic [N_CARDS-1:0] eff_sel;
   logic [PC_W-1:0]    pc;
   logic [TYPE_W-1:0]  type_a;
   logic [TYPE_W-1:0]  type_b;
   logic               pair_seen;
   logic               eq_c;

   always_comb begin
      eff_sel = sel & ~hidden;
      pc      = '0;
      type_a  = '0;
      type_b  = '0;
      // The running count tells us whether a set bit is the first or the
      // second one found, so the loop yields popcount and both types together.
      for (int unsigned i = 0; i < N_CARDS; i++) begin
         if (eff_sel[i]) begin
            if (pc == PC_W'(0)) begin
               type_a = types[i*TYPE_W +: TYPE_W];
            end else if (pc == PC_W'(1)) begin
               type_b = types[i*TYPE_W +: TYPE_W];
            end
            pc = pc + PC_W'(1);
         end
      end
      pair_seen = (pc >= PC_W'(2));
      // Selecting three or more cards is illegal and always counts as a miss.
      eq_c      = (type_a == type_b) && (pc == PC_W'(2));
   end

   // ---------------------------------------------------------------------------
   // Judge FSM with registered outputs
   // ---------------------------------------------------------------------------
   state_t            state_q;
   logic              ms_q;
   logic              mf_q;
   logic              busy_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              done_q;
`ifdef JUDGE_DELAY_EN
   logic              eq_q;
   logic [DLY_W-1:0]  dly_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ms_q    <= 1'b0;
         mf_q    <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef JUDGE_DELAY_EN
         eq_q    <= 1'b0;
         dly_q   <= '0;
`endif
      end else begin
         // Pulses last one cycle by default. Only the transition into
         // PULSE raises them.
         ms_q   <= 1'b0;
         mf_q   <= 1'b0;
         done_q <= done_q | (cnt_q == HALF);

         case (state_q)
            IDLE: begin
               if (pair_seen && !done_q) begin
                  state_q <= EVAL;
                  busy_q  <= 1'b1;
               end
            end

            EVAL: begin
               if (!pair_seen) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
`ifdef JUDGE_DELAY_EN
                  eq_q    <= eq_c;
                  dly_q   <= '0;
                  state_q <= HOLD;
`else
                  ms_q    <= eq_c;
                  mf_q    <= ~eq_c;
                  state_q <= PULSE;
`endif
               end
            end

`ifdef JUDGE_DELAY_EN
            HOLD: begin
               if (!pair_seen) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (dly_q == DLY_LAST) begin
                  ms_q    <= eq_q;
                  mf_q    <= ~eq_q;
                  state_q <= PULSE;
               end else begin
                  dly_q   <= dly_q + DLY_W'(1);
               end
            end
`endif

            PULSE: begin
               if (ms_q && (cnt_q != HALF)) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
               state_q <= WAIT;
            end

            // The cards drop sel a couple of cycles after the pulse. Staying
            // here until the pair is gone stops the same pair being judged
            // twice.
            WAIT: begin
               if (!pair_seen) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign ms        = ms_q;
   assign mf        = mf_q;
   assign busy      = busy_q;
   assign match_cnt = cnt_q;
   assign done      = done_q;

endmodule

// File: tb/tb_match_judge.sv
module tb_match_judge;

   localparam int unsigned N    = 16;
   localparam int unsigned TW   = 3;
   localparam int unsigned DLY  = 8;
   localparam int unsigned HALF = N / 2;
`ifdef JUDGE_DELAY_EN
   localparam int unsigned P = 2 + DLY;
`else
   localparam int unsigned P = 2;
`endif
   // Drop point for the abort scenario: inside HOLD when the delay is
   // enabled, otherwise during the evaluation cycle.
   localparam int unsigned L_ABORT = (P > 2) ? 5 : 1;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      sel;
   logic [N-1:0]      hidden;
   logic [N*TW-1:0]   types;
   logic              ms;
   logic              mf;
   logic              busy;
   logic [3:0]        match_cnt;
   logic              done;

   int                checks = 0;
   int                errors = 0;

   // Reference state: which cards the card array has retired, pair count,
   // and whether the game has finished.
   logic [N-1:0]      hid_m;
   int unsigned       cnt_m;
   bit                done_m;

   always #5 clk = ~clk;

   match_judge #(
      .N_CARDS   (N),
      .TYPE_W    (TW),
      .DELAY_CYC (DLY)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sel       (sel),
      .hidden    (hidden),
      .types     (types),
      .ms        (ms),
      .mf        (mf),
      .busy      (busy),
      .match_cnt (match_cnt),
      .done      (done)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [TW-1:0] type_of(input logic [N*TW-1:0] ty, input int unsigned i);
      return ty[i*TW +: TW];
   endfunction

   // Apply selection s with types ty for L cycles, then release it. Outputs
   // are predicted from the rules of the judge:
   //  - a verdict needs at least two effective cards and a game that is not
   //    finished;
   //  - the pulse comes P cycles after the selection appears, provided the
   //    pair is held for all P cycles before it;
   //  - busy covers cycle 1 to the cycle the pair disappears, and always
   //    includes the cycle after the pulse.
   task automatic run_txn(input logic [N-1:0] s, input logic [N*TW-1:0] ty, input int unsigned L);
      logic [N-1:0] v;
      int unsigned  pc, a, b, found, last, span;
      bit           active, pulse, eq, inc;
      v     = s & ~hid_m;
      pc    = $countones(v);
      a     = 0;
      b     = 0;
      found = 0;
      for (int unsigned i = 0; i < N; i++) begin
         if (v[i]) begin
            if (found == 0) a = i;
            else if (found == 1) b = i;
            found++;
         end
      end
      eq     = (pc == 2) && (type_of(ty, a) == type_of(ty, b));
      active = !done_m && (pc >= 2);
      pulse  = active && (L >= P);
      inc    = pulse && eq && (cnt_m < HALF);
      last   = !active ? 0 : (pulse ? ((L > P + 1) ? L : P + 1) : L);
      span   = ((L > last) ? L : last) + 3;

      @(posedge clk); #1;
      sel    = s;
      types  = ty;
      hidden = hid_m;
      for (int unsigned k = 0; k < span; k++) begin
         @(negedge clk);
         check_eq("ms", ms, pulse && eq && (k == P));
         check_eq("mf", mf, pulse && !eq && (k == P));
         check_eq("busy", busy, active && (k >= 1) && (k <= last));
         check_eq("match_cnt", match_cnt, (inc && (k >= P + 1)) ? cnt_m + 1 : cnt_m);
         check_eq("done", done, done_m || (inc && (cnt_m + 1 == HALF) && (k >= P + 2)));
         @(posedge clk); #1;
         if (k + 1 == L) begin
            sel = '0;
            if (pulse && eq) hid_m = hid_m | v;
            hidden = hid_m;
         end
      end
      if (inc) cnt_m++;
      if (cnt_m == HALF) done_m = 1'b1;
   endtask

   // Choose two distinct cards that are still in play.
   task automatic pick_live_pair(output bit ok, output int unsigned a, output int unsigned b);
      int unsigned q[$];
      int unsigned j;
      for (int unsigned i = 0; i < N; i++) if (!hid_m[i]) q.push_back(i);
      ok = (q.size() >= 2);
      a  = 0;
      b  = 0;
      if (ok) begin
         j = $urandom_range(q.size() - 1);
         a = q[j];
         q.delete(j);
         j = $urandom_range(q.size() - 1);
         b = q[j];
      end
   endtask

   function automatic logic [N*TW-1:0] rand_types();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[N*TW-1:0];
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N*TW-1:0] ty;
      logic [N-1:0]    s;
      int unsigned     a, b, c, kind;
      bit              ok;

      rst    = 1'b1;
      sel    = '0;
      hidden = '0;
      types  = '0;
      hid_m  = '0;
      cnt_m  = 0;
      done_m = 1'b0;

      repeat (2) @(negedge clk);
      check_eq("rst_ms", ms, 0);
      check_eq("rst_mf", mf, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_cnt", match_cnt, 0);
      check_eq("rst_done", done, 0);
      rst = 1'b0;

      // Different types: one mf pulse.
      ty = '0; ty[0*TW +: TW] = 3'd1; ty[4*TW +: TW] = 3'd2;
      run_txn(16'h0011, ty, P + 4);
      // Three cards selected: always a miss.
      ty = rand_types(); ty[1*TW +: TW] = ty[0*TW +: TW];
      run_txn(16'h0007, ty, P + 3);
      // A lone card held for a long time: no pulse, never busy.
      run_txn(16'h0001, ty, 100);
      // Matching pair: one ms pulse, count goes to 1.
      ty = '0; ty[0*TW +: TW] = 3'd3; ty[2*TW +: TW] = 3'd3;
      run_txn(16'h0005, ty, P + 6);

      // Reset while waiting for a matched pair to drop.
      ty = rand_types(); ty[9*TW +: TW] = ty[6*TW +: TW];
      @(posedge clk); #1;
      sel = 16'h0240; types = ty; hidden = hid_m;
      repeat (P + 2) @(posedge clk);
      #2;
      check_eq("pre_rst_cnt", match_cnt, cnt_m + 1);
      check_eq("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      check_eq("midrst_ms", ms, 0);
      check_eq("midrst_mf", mf, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_cnt", match_cnt, 0);
      check_eq("midrst_done", done, 0);
      @(negedge clk);
      sel = '0; hidden = '0; hid_m = '0; cnt_m = 0; done_m = 1'b0;
      rst = 1'b0;

      // Matching pair withdrawn before the verdict: no pulse.
      ty = rand_types(); ty[3*TW +: TW] = ty[1*TW +: TW];
      run_txn(16'h000A, ty, L_ABORT);

      // Randomized mix of selections.
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(4);
         ty   = rand_types();
         a    = $urandom_range(N - 1);
         b    = (a + 1 + $urandom_range(N - 2)) % N;
         c    = (b + 1 + $urandom_range(N - 3)) % N;
         if (c == a) c = (c + 1) % N;
         if (c == b) c = (c + 1) % N;
         if (c == a) c = (c + 1) % N;
         s = '0;
         case (kind)
            0: begin
               pick_live_pair(ok, a, b);
               if (ok) ty[b*TW +: TW] = ty[a*TW +: TW];
               s[a] = 1'b1; s[b] = 1'b1;
               run_txn(s, ty, P + 1 + $urandom_range(5));
            end
            1: begin
               s[a] = 1'b1; s[b] = 1'b1;
               run_txn(s, ty, P + 1 + $urandom_range(5));
            end
            2: begin
               s[a] = 1'b1; s[b] = 1'b1; s[c] = 1'b1;
               run_txn(s, ty, P + 1 + $urandom_range(5));
            end
            3: begin
               s[a] = 1'b1;
               run_txn(s, ty, 1 + $urandom_range(P + 4));
            end
            default: begin
               pick_live_pair(ok, a, b);
               if (ok) ty[b*TW +: TW] = ty[a*TW +: TW];
               s[a] = 1'b1; s[b] = 1'b1;
               run_txn(s, ty, 1 + $urandom_range(P - 1));
            end
         endcase
      end

      // Clear the board.
      for (int n = 0; n < 16 && cnt_m < HALF; n++) begin
         pick_live_pair(ok, a, b);
         if (ok) begin
            ty = rand_types();
            ty[b*TW +: TW] = ty[a*TW +: TW];
            s = '0; s[a] = 1'b1; s[b] = 1'b1;
            run_txn(s, ty, P + 1 + $urandom_range(3));
         end
      end
      @(negedge clk);
      check_eq("final_cnt", match_cnt, HALF);
      check_eq("final_done", done, 1);

      // The game is over: even a fresh matching pair is ignored.
      hid_m = '0;
      ty = '0; ty[0*TW +: TW] = 3'd5; ty[1*TW +: TW] = 3'd5;
      run_txn(16'h0003, ty, P + 4);
      ty = '0; ty[0*TW +: TW] = 3'd1; ty[5*TW +: TW] = 3'd2;
      run_txn(16'h0021, ty, P + 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
